// File: rtl/rom_burst_pkg.sv
// Shared types and constant table for the ROM burst reader.
// Holds the FSM state encoding, the eight default 14-bit ROM words and the
// lookup function that widens or narrows them to the configured data width.
package rom_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } burstState_e;

  localparam int ROM_WORD_W  = 14;
  localparam int ROM_ENTRIES = 8;
  localparam int MAX_W       = 64;

  localparam logic [ROM_WORD_W-1:0] DEFAULT_WORDS [0:ROM_ENTRIES-1] = '{
    14'h1555, 14'h1999, 14'h19E7, 14'h2294,
    14'h010C, 14'h0E03, 14'h006C, 14'h05AD
  };

  // Returns the table word for addr, zero-extended and masked to dataW bits.
  // Indices past the populated table read as zero.
  function automatic logic [MAX_W-1:0] rom_word(input logic [31:0] addr, input int dataW);
    logic [MAX_W-1:0] word;
    logic [MAX_W-1:0] mask;
    if (addr < 32'(ROM_ENTRIES)) begin
      word = {{(MAX_W-ROM_WORD_W){1'b0}}, DEFAULT_WORDS[addr[2:0]]};
    end else begin
      word = {MAX_W{1'b0}};
    end
    if (dataW < MAX_W) begin
      mask = (64'd1 << dataW) - 64'd1;
    end else begin
      mask = {MAX_W{1'b1}};
    end
    return word & mask;
  endfunction

endpackage

// File: rtl/rom_burst_table.sv
// Combinational ROM lookup, parametrised on data and address width.
module rom_burst_table
  import rom_burst_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Pure table lookup; no state.
  always_comb begin
    data = DATA_W'(rom_word(32'(addr), DATA_W));
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Streams a burst of ROM words over valid/ready, one word per cycle, with
// address wrap, optional looping, abort and done/err pulses.
// Optional feature: define ROM_PARITY_EN to add par_out, the registered
// XOR-reduce parity of data_out.
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   burst_len,
  input  logic              loop_en,
  input  logic              stop,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last_out,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef ROM_PARITY_EN
  ,
  output logic              par_out
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};

  burstState_e       state_r, stateNext_s;
  logic [ADDR_W-1:0] addr_r, addrNext_s, startAddr_r, startAddrNext_s, lookupAddr_s;
  logic [ADDR_W:0]   remain_r, remainNext_s, burstLen_r, burstLenNext_s;
  logic              loopEn_r, loopEnNext_s;
  logic [DATA_W-1:0] data_r, tableWord_s;
  logic              valid_r, validNext_s, last_r, lastNext_s;
  logic              busy_r, busyNext_s, done_r, doneNext_s, err_r, errNext_s;
  logic              loadWord_s, handshake_s, lenLegal_s;

  assign handshake_s = valid_r & ready_in;
  assign lenLegal_s  = (burst_len != {(ADDR_W+1){1'b0}}) && (burst_len <= DEPTH_C);

  rom_burst_table #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uTable (
    .addr (lookupAddr_s),
    .data (tableWord_s)
  );

  // Next-state and next-output decode; every register's next value starts as a hold.
  always_comb begin
    stateNext_s     = state_r;
    addrNext_s      = addr_r;
    remainNext_s    = remain_r;
    lastNext_s      = last_r;
    startAddrNext_s = startAddr_r;
    burstLenNext_s  = burstLen_r;
    loopEnNext_s    = loopEn_r;
    lookupAddr_s    = addr_r;
    loadWord_s      = 1'b0;
    errNext_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (lenLegal_s) begin
            startAddrNext_s = start_addr;
            burstLenNext_s  = burst_len;
            loopEnNext_s    = loop_en;
            lookupAddr_s    = start_addr;
            addrNext_s      = start_addr;
            remainNext_s    = burst_len - ONE_LEN;
            lastNext_s      = (burst_len == ONE_LEN);
            loadWord_s      = 1'b1;
            stateNext_s     = SEND;
          end else begin
            errNext_s = 1'b1;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      SEND: begin
        if (stop) begin
          // Abort wins over any reload; the current word only moved if ready_in was high.
          stateNext_s = DONE;
          lastNext_s  = 1'b0;
        end else if (handshake_s) begin
          if (remain_r != {(ADDR_W+1){1'b0}}) begin
            addrNext_s   = addr_r + ADDR_W'(1'b1);
            lookupAddr_s = addr_r + ADDR_W'(1'b1);
            remainNext_s = remain_r - ONE_LEN;
            lastNext_s   = (remain_r == ONE_LEN);
            loadWord_s   = 1'b1;
          end else if (loopEn_r) begin
            // Restart the pass straight away so looping has no bubble.
            addrNext_s   = startAddr_r;
            lookupAddr_s = startAddr_r;
            remainNext_s = burstLen_r - ONE_LEN;
            lastNext_s   = (burstLen_r == ONE_LEN);
            loadWord_s   = 1'b1;
          end else begin
            stateNext_s = DONE;
            lastNext_s  = 1'b0;
          end
        end else begin
          stateNext_s = SEND;
        end
      end
      DONE: begin
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
        lastNext_s  = 1'b0;
      end
    endcase
    validNext_s = (stateNext_s == SEND);
    busyNext_s  = (stateNext_s != IDLE);
    doneNext_s  = (stateNext_s == DONE);
  end

  // State, counters and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      startAddr_r <= {ADDR_W{1'b0}};
      remain_r    <= {(ADDR_W+1){1'b0}};
      burstLen_r  <= {(ADDR_W+1){1'b0}};
      loopEn_r    <= 1'b0;
      data_r      <= {DATA_W{1'b0}};
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= stateNext_s;
      addr_r      <= addrNext_s;
      startAddr_r <= startAddrNext_s;
      remain_r    <= remainNext_s;
      burstLen_r  <= burstLenNext_s;
      loopEn_r    <= loopEnNext_s;
      data_r      <= loadWord_s ? tableWord_s : data_r;
      valid_r     <= validNext_s;
      last_r      <= lastNext_s;
      busy_r      <= busyNext_s;
      done_r      <= doneNext_s;
      err_r       <= errNext_s;
    end
  end

  assign valid_out = valid_r;
  assign data_out  = data_r;
  assign addr_out  = addr_r;
  assign last_out  = last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

`ifdef ROM_PARITY_EN
  logic par_r;

  function automatic logic evenParity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  // Parity is captured together with the data word so the two stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_r <= 1'b0;
    end else begin
      par_r <= loadWord_s ? evenParity(tableWord_s) : par_r;
    end
  end

  assign par_out = par_r;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader at default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rom_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  startAddr = 3'd0;
  logic [3:0]  burstLen = 4'd0;
  logic        loopEn = 1'b0;
  logic        stop = 1'b0;
  logic        readyIn = 1'b0;
  logic        validOut;
  logic [13:0] dataOut;
  logic [2:0]  addrOut;
  logic        lastOut;
  logic        busy;
  logic        done;
  logic        err;
`ifdef ROM_PARITY_EN
  logic        parOut;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rom_burst_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (startAddr),
    .burst_len  (burstLen),
    .loop_en    (loopEn),
    .stop       (stop),
    .ready_in   (readyIn),
    .valid_out  (validOut),
    .data_out   (dataOut),
    .addr_out   (addrOut),
    .last_out   (lastOut),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef ROM_PARITY_EN
    ,
    .par_out    (parOut)
`endif
  );

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({validOut, dataOut, addrOut, lastOut, busy, done, err} !== 21'd0) begin
      failed++;
      $display("FAIL reset_outputs got v=%b d=%h a=%0d l=%b b=%b dn=%b e=%b exp all 0",
               validOut, dataOut, addrOut, lastOut, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_burst();
    logic [13:0] exp [0:7];
    exp[0] = 14'h1555; exp[1] = 14'h1999; exp[2] = 14'h19E7; exp[3] = 14'h2294;
    exp[4] = 14'h010C; exp[5] = 14'h0E03; exp[6] = 14'h006C; exp[7] = 14'h05AD;
    start = 1'b1; startAddr = 3'd0; burstLen = 4'd8; loopEn = 1'b0; readyIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (validOut !== 1'b1 || dataOut !== exp[i] || addrOut !== 3'(i) ||
          lastOut !== (i == 7) || busy !== 1'b1) begin
        failed++;
        $display("FAIL full_word%0d got v=%b d=%h a=%0d l=%b b=%b exp v=1 d=%h a=%0d l=%b b=1",
                 i, validOut, dataOut, addrOut, lastOut, busy, exp[i], i, (i == 7));
      end
`ifdef ROM_PARITY_EN
      tests++;
      if (parOut !== ^exp[i]) begin
        failed++;
        $display("FAIL parity%0d got %b exp %b", i, parOut, ^exp[i]);
      end
`endif
    end
    @(negedge clk);
    tests++;
    if (validOut !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      failed++;
      $display("FAIL full_done got v=%b dn=%b b=%b exp v=0 dn=1 b=1", validOut, done, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL full_idle got dn=%b b=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] exp [0:3];
    logic [2:0]  expA [0:3];
    exp[0] = 14'h006C; exp[1] = 14'h05AD; exp[2] = 14'h1555; exp[3] = 14'h1999;
    expA[0] = 3'd6; expA[1] = 3'd7; expA[2] = 3'd0; expA[3] = 3'd1;
    start = 1'b1; startAddr = 3'd6; burstLen = 4'd4; readyIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (validOut !== 1'b1 || dataOut !== exp[i] || addrOut !== expA[i] || lastOut !== (i == 3)) begin
        failed++;
        $display("FAIL wrap_word%0d got v=%b d=%h a=%0d l=%b exp v=1 d=%h a=%0d l=%b",
                 i, validOut, dataOut, addrOut, lastOut, exp[i], expA[i], (i == 3));
      end
    end
    @(negedge clk);
    tests++;
    if (validOut !== 1'b0 || done !== 1'b1) begin
      failed++;
      $display("FAIL wrap_done got v=%b dn=%b exp v=0 dn=1", validOut, done);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    logic       rdy [0:3];
    logic [13:0] exp [0:3];
    int xfers = 0;
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1;
    exp[0] = 14'h19E7; exp[1] = 14'h2294; exp[2] = 14'h2294; exp[3] = 14'h2294;
    start = 1'b1; startAddr = 3'd2; burstLen = 4'd2; readyIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      readyIn = rdy[i];
      tests++;
      if (validOut !== 1'b1 || dataOut !== exp[i] || lastOut !== (i != 0)) begin
        failed++;
        $display("FAIL stall_cyc%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 i, validOut, dataOut, lastOut, exp[i], (i != 0));
      end
      if (validOut && readyIn) xfers++;
    end
    @(negedge clk);
    readyIn = 1'b1;
    tests++;
    if (xfers != 2 || validOut !== 1'b0 || done !== 1'b1) begin
      failed++;
      $display("FAIL stall_end got xfers=%0d v=%b dn=%b exp xfers=2 v=0 dn=1", xfers, validOut, done);
    end
    @(negedge clk);
  endtask

  task automatic test_loop_stop();
    int xfers = 0;
    start = 1'b1; startAddr = 3'd3; burstLen = 4'd2; loopEn = 1'b1; readyIn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (validOut !== 1'b1 || dataOut !== ((k % 2 == 0) ? 14'h2294 : 14'h010C) ||
          lastOut !== (k % 2 == 1)) begin
        failed++;
        $display("FAIL loop_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", k, validOut, dataOut,
                 lastOut, (k % 2 == 0) ? 14'h2294 : 14'h010C, (k % 2 == 1));
      end
      if (validOut && readyIn) xfers++;
    end
    @(negedge clk);
    readyIn = 1'b0;
    stop = 1'b1;
    loopEn = 1'b0;
    tests++;
    if (validOut !== 1'b1 || dataOut !== 14'h2294) begin
      failed++;
      $display("FAIL loop_prestop got v=%b d=%h exp v=1 d=2294", validOut, dataOut);
    end
    if (validOut && readyIn) xfers++;
    @(negedge clk);
    stop = 1'b0;
    tests++;
    if (validOut !== 1'b0 || done !== 1'b1 || xfers != 6) begin
      failed++;
      $display("FAIL loop_stop got v=%b dn=%b xfers=%0d exp v=0 dn=1 xfers=6", validOut, done, xfers);
    end
    @(negedge clk);
    readyIn = 1'b1;
  endtask

  task automatic test_bad_len();
    logic [3:0] lens [0:1];
    lens[0] = 4'd0; lens[1] = 4'd9;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; burstLen = lens[i]; startAddr = 3'd1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (err !== 1'b1 || busy !== 1'b0 || validOut !== 1'b0) begin
        failed++;
        $display("FAIL badlen%0d_pulse got e=%b b=%b v=%b exp e=1 b=0 v=0", lens[i], err, busy, validOut);
      end
      @(negedge clk);
      tests++;
      if (err !== 1'b0 || busy !== 1'b0 || validOut !== 1'b0) begin
        failed++;
        $display("FAIL badlen%0d_after got e=%b b=%b v=%b exp all 0", lens[i], err, busy, validOut);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    start = 1'b1; startAddr = 3'd0; burstLen = 4'd8; loopEn = 1'b0; readyIn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    tests++;
    if (addrOut !== 3'd4 || dataOut !== 14'h010C) begin
      failed++;
      $display("FAIL midrst_pre got a=%0d d=%h exp a=4 d=010C", addrOut, dataOut);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({validOut, dataOut, addrOut, lastOut, busy, done, err} !== 21'd0) begin
      failed++;
      $display("FAIL midrst_async got v=%b d=%h a=%0d l=%b b=%b dn=%b e=%b exp all 0",
               validOut, dataOut, addrOut, lastOut, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (validOut !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL midrst_quiet got v=%b b=%b exp 0 0", validOut, busy);
    end
    start = 1'b1; startAddr = 3'd5; burstLen = 4'd1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (validOut !== 1'b1 || dataOut !== 14'h0E03 || addrOut !== 3'd5 || lastOut !== 1'b1) begin
      failed++;
      $display("FAIL midrst_single got v=%b d=%h a=%0d l=%b exp v=1 d=0E03 a=5 l=1",
               validOut, dataOut, addrOut, lastOut);
    end
    @(negedge clk);
    tests++;
    if (validOut !== 1'b0 || done !== 1'b1) begin
      failed++;
      $display("FAIL midrst_done got v=%b dn=%b exp v=0 dn=1", validOut, done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_wrap();
    test_stall();
    test_loop_stop();
    test_bad_len();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Parametrised sequential successor to the fixed 8x14 lookup ROM.
- Accepts a burst request (start address, length, loop mode) and streams ROM words out over a valid/ready interface at one word per cycle.
- Address wrap-around, abort and completion signalling are built in.
- Sits between control FSMs and any datapath consumer of constant tables.

Parameters:
- DATA_W, 14, ROM word width. Default contents are zero-extended if wider, or take the low DATA_W bits if narrower.
- ADDR_W, 3, address width. DEPTH = 2**ADDR_W is fixed; entries at index 8 and above read 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  burst request pulse; sampled only in IDLE
- start_addr  in  ADDR_W  first address of burst
- burst_len  in  ADDR_W+1  words per pass, legal 1..DEPTH
- loop_en  in  1  sampled with start; 1 = repeat the pass until stop
- stop  in  1  abort request while streaming
- ready_in  in  1  consumer ready
- valid_out  out  1  data_out/addr_out valid
- data_out  out  DATA_W  ROM word
- addr_out  out  ADDR_W  address of data_out
- last_out  out  1  high with the final word of a pass
- busy  out  1  high in SEND and DONE
- done  out  1  one-cycle pulse at end of burst or abort
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Internal counters and address register 0. Applies immediately, mid-burst included; no word is delivered after reset.
- Default table: 0:0x1555, 1:0x1999, 2:0x19E7, 3:0x2294, 4:0x010C, 5:0x0E03, 6:0x006C, 7:0x05AD.
- States: IDLE, SEND, DONE.
- IDLE, start=1, burst_len in 1..DEPTH:
  - Capture start_addr, burst_len and loop_en.
  - Load data_out=rom[start_addr], addr_out=start_addr.
  - Load remaining=burst_len-1 and last_out=(burst_len==1).
  - Go to SEND; valid_out=1 on the next cycle. Latency start->valid is 1 cycle.
- IDLE, start=1, burst_len==0 or >DEPTH: err pulses 1 cycle and state stays IDLE.
- start outside IDLE: ignored, no err.
- SEND, handshake (valid_out & ready_in):
  - If remaining>0: addr = addr+1 mod DEPTH (wraps 7->0 at default), load the word, decrement remaining, last_out=(remaining==1). Back-to-back throughput is 1 word/cycle.
  - If remaining==0 and loop_en: reload captured start_addr and burst_len, same as start. No bubble.
  - If remaining==0 and !loop_en: go to DONE; valid_out=0 next cycle.
- SEND, no handshake: data_out, addr_out and last_out held stable. valid_out is never withdrawn except by stop.
- SEND, stop=1:
  - The word on the bus in that cycle transfers only if ready_in=1 in the same cycle.
  - Next state is DONE and valid_out=0 next cycle. Stop has priority over loop reload.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. A start arriving in DONE is ignored.
- stop in IDLE or DONE: no effect.

Optional Feature:
- Macro ROM_PARITY_EN.
- Defined: adds output port par_out (1 bit) = even parity (XOR-reduce) of data_out, registered alongside data_out, reset 0. Default table gives par_out=1 at addr 0.
- Undefined: no par_out port and no parity logic; behaviour otherwise identical.

Decomposition:
- Package rom_burst_pkg: state enum (IDLE, SEND, DONE), DEFAULT_WORDS constant array (8 x 14 bits), function rom_word(addr, DATA_W) returning the extended/truncated or zero word.
- Sub-module rom_burst_table: purely combinational, parametrised DATA_W/ADDR_W lookup using the package function. The FSM, counters and output registers stay in rom_burst_reader.

Test Plan:
- Reset, then start_addr=0, burst_len=8, loop_en=0, ready_in=1 -> valid 1 cycle after start; data 0x1555,0x1999,0x19E7,0x2294,0x010C,0x0E03,0x006C,0x05AD on consecutive cycles; last_out only with 0x05AD; done pulse 1 cycle later.
- start_addr=6, burst_len=4 -> addr_out 6,7,0,1 with data 0x006C,0x05AD,0x1555,0x1999 (wrap check).
- start_addr=2, burst_len=2, ready_in toggled 1,0,0,1 -> 0x19E7 then 0x2294 held stable through the stall; exactly 2 transfers counted.
- loop_en=1, start_addr=3, burst_len=2 -> 0x2294,0x010C repeating with last_out on each 0x010C; stop asserted with ready_in=0 -> valid_out drops next cycle, done pulses, no extra transfer.
- burst_len=0, then burst_len=9 (ADDR_W=3) -> err pulse each time, busy stays 0, valid_out stays 0.
- Assert rst_n=0 mid-burst at addr 4 -> all outputs 0 asynchronously; after release a fresh start_addr=5, burst_len=1 yields 0x0E03 with last_out=1.
